// File: rtl/operand_fetch.sv
// Operand fetch stage: register file, in-flight scoreboard, write-back bypass and
// a registered operand packet handed to the ALU over valid/ready.

module operand_fetch_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             set_pend,
    output logic [WIDTH-1:0] value,
    output logic             pending
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value   <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_en)
                value <= wr_data;
            // a new producer issued this cycle outranks the retiring one
            if (set_pend)
                pending <= 1'b1;
            else if (wr_en)
                pending <= 1'b0;
        end
    end
endmodule

module operand_fetch #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [RW-1:0]    sr1,
    input  logic [RW-1:0]    sr2,
    input  logic             use_imm,
    input  logic [4:0]       imm5,
    input  logic [1:0]       alu_sel,
    input  logic [RW-1:0]    dr,
    input  logic             dr_wr,
    input  logic             wb_en,
    input  logic [RW-1:0]    wb_dr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [1:0]       select,
    output logic [RW-1:0]    op_dr,
    output logic             op_dr_wr
);
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       sel;
        logic [RW-1:0]    dr;
        logic             dr_wr;
    } pkt_t;

    logic [WIDTH-1:0] rf [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] wb_hit;
    logic [NREGS-1:0] set_hit;
    logic [NREGS-1:0] pend_eff;
    logic             sr2_used;
    logic             hazard;
    logic             fire;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_reg;
    pkt_t             pkt_next;
    pkt_t             pkt_q;

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_reg
            assign wb_hit[g]  = wb_en && (wb_dr == RW'(g));
            assign set_hit[g] = fire && dr_wr && (dr == RW'(g));
            operand_fetch_reg #(.WIDTH(WIDTH)) u_reg (
                .clk      (clk),
                .rst      (rst),
                .wr_en    (wb_hit[g]),
                .wr_data  (wb_data),
                .set_pend (set_hit[g]),
                .value    (rf[g]),
                .pending  (pending[g])
            );
        end
    endgenerate

    // a write-back landing this cycle already satisfies its consumers
    assign pend_eff = pending & ~wb_hit;

    // only ADD and AND consume a register B operand
    assign sr2_used = ~use_imm & ~alu_sel[1];
    assign hazard   = pend_eff[sr1] | (sr2_used & pend_eff[sr2]) | (dr_wr & pend_eff[dr]);

    assign issue_ready = ~hazard & (~op_valid | op_ready);
    assign fire        = issue_valid & issue_ready;

    assign a_next = wb_hit[sr1] ? wb_data : rf[sr1];
    assign b_reg  = wb_hit[sr2] ? wb_data : rf[sr2];

    always_comb begin
        pkt_next       = '0;
        pkt_next.a     = a_next;
        pkt_next.b     = use_imm ? {{(WIDTH-5){imm5[4]}}, imm5} : b_reg;
        pkt_next.sel   = alu_sel;
        pkt_next.dr    = dr;
        pkt_next.dr_wr = dr_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q    <= '0;
            op_valid <= 1'b0;
        end else if (fire) begin
            pkt_q    <= pkt_next;
            op_valid <= 1'b1;
        end else if (op_ready) begin
            op_valid <= 1'b0;
        end
    end

    assign A        = pkt_q.a;
    assign B        = pkt_q.b;
    assign select   = pkt_q.sel;
    assign op_dr    = pkt_q.dr;
    assign op_dr_wr = pkt_q.dr_wr;
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Upstream operand stage for the 16-bit ALU (ADD / AND / NOT A / PASS A).
- Holds the architectural register file and resolves the SR1/SR2/imm5 operands.
- Tracks in-flight destination registers with a scoreboard.
- Presents a registered operand packet (A, B, select) to the execute stage over a valid/ready handshake; write-back returns through a dedicated port.

Parameters:
- WIDTH, 16, datapath width.
- NREGS, 8, number of registers. Register index width is log2(NREGS) = 3.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- issue_valid  in  1  decoder presents an instruction.
- issue_ready  out  1  stage accepts the instruction this cycle.
- sr1  in  3  source register for A.
- sr2  in  3  source register for B.
- use_imm  in  1  B comes from imm5 instead of sr2.
- imm5  in  5  signed immediate.
- alu_sel  in  2  ALU op: 00 ADD, 01 AND, 10 NOT A, 11 PASS A.
- dr  in  3  destination register.
- dr_wr  in  1  instruction writes dr.
- wb_en  in  1  write-back strobe.
- wb_dr  in  3  write-back register.
- wb_data  in  16  write-back value.
- op_valid  out  1  operand packet valid.
- op_ready  in  1  execute stage accepts the packet.
- A  out  16  operand A.
- B  out  16  operand B.
- select  out  2  ALU select.
- op_dr  out  3  destination of the packet.
- op_dr_wr  out  1  packet writes op_dr.

Behaviour:
- Reset (async) clears: all registers to 0, all pending bits to 0, op_valid to 0, and A, B, select, op_dr, op_dr_wr to 0. Reset asserted mid-operation drops the in-flight packet.
- Write-back: when wb_en=1, reg[wb_dr] <= wb_data at the clock edge and pending[wb_dr] clears, unless it is re-set that same cycle.
- Operand use:
  - sr1 is used when alu_sel is any value (all ops read A).
  - sr2 is used only when use_imm=0 and alu_sel is 00 or 01.
- Effective pending: pend_eff[r] = pending[r] & ~(wb_en & wb_dr==r). A write-back in the same cycle resolves the hazard.
- Hazard (any of):
  - pend_eff[sr1].
  - sr2 used and pend_eff[sr2].
  - dr_wr and pend_eff[dr] (WAW).
- Handshake:
  - issue_ready = ~hazard & (~op_valid | op_ready).
  - A fire occurs when issue_valid & issue_ready.
  - issue_ready does not depend on issue_valid.
- Operand read with bypass:
  - A_next = (wb_en & wb_dr==sr1) ? wb_data : reg[sr1].
  - B_next = use_imm ? sign-extend(imm5) to 16 bits : (bypassed) reg[sr2].
  - When sr2 is unused and use_imm=0, B_next is still reg[sr2]; the value is don't-care for the ALU but is deterministic.
- On fire: A, B, select=alu_sel, op_dr=dr, op_dr_wr=dr_wr register at the edge; op_valid <= 1; if dr_wr, pending[dr] <= 1.
- Set and clear of the same pending bit in one cycle: set wins.
- Output hold: while op_valid & ~op_ready, A, B, select, op_dr and op_dr_wr stay stable and issue_ready=0.
- Drain: op_ready=1 with no fire gives op_valid <= 0.
- Throughput: back-to-back fire is allowed with op_ready held 1, giving 1 op/cycle.
- Latency: 1 cycle from fire to op_valid.
- Pending bits are cleared only by write-back or reset. If no write-back ever arrives, the stage stalls; no timeout.

Test Plan:
- Reset then wb_en R1=0x0005, R2=0x0003; issue ADD sr1=1 sr2=2 dr=3 dr_wr=1, op_ready=1 -> next cycle op_valid=1, A=0x0005, B=0x0003, select=00, op_dr=3, pending[3]=1.
- Immediate: issue use_imm=1 imm5=5'b10000, sr1=1, AND -> B=0xFFF0. imm5=5'b01111 -> B=0x000F.
- RAW stall:
  - R3 pending; issue ADD sr1=3 -> issue_ready=0 for as many cycles as no write-back.
  - Then wb_en wb_dr=3 wb_data=0x1234 -> issue_ready=1 that same cycle and A=0x1234 (bypass).
- Backpressure: op_valid=1, op_ready=0 for 3 cycles with issue_valid=1 -> issue_ready=0, A/B/select unchanged; op_ready=1 -> next packet loads on that edge.
- NOT/PASS: R5 pending; issue alu_sel=10 sr1=1 sr2=5 use_imm=0 -> no stall (sr2 unused); issue alu_sel=00 sr2=5 -> stall.
- WAW plus same-cycle set/clear: R4 pending; issue dr=4 dr_wr=1 while wb_en wb_dr=4 -> fire, pending[4]=1 after the edge, reg[4]=wb_data. Async Reset mid-stream -> op_valid=0 and pending=0 immediately.
